// File: rtl/gol_pkg.sv
// Shared types for the grid transmit path: default geometry, snapshot/row
// types and the transmitter state encoding.
package gol_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam int DEF_GENW = 16;
  localparam int GRID_W   = DEF_ROWS * DEF_COLS;

  typedef logic [GRID_W-1:0]   grid_t;
  typedef logic [DEF_COLS-1:0] row_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage : gol_pkg

// File: rtl/grid_row_tx_hold.sv
// Single-entry snapshot register with a full flag; holds the next generation
// while the current one is still streaming.
module grid_hold_reg
  import gol_pkg::*;
#(
  parameter int W = GRID_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // Next-state for the slot; a load takes precedence over a clear.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (clear) begin
      data_d = {W{1'b0}};
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Slot storage with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= {W{1'b0}};
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule : grid_hold_reg

// File: rtl/grid_row_tx.sv
// Serialises one grid snapshot per handshake into ROWS row-wide beats, with a
// one-deep pending slot so the next generation can be captured mid-frame.
module grid_row_tx
  import gol_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int GENW = DEF_GENW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grid_valid,
  input  logic [ROWS*COLS-1:0]     grid,
  output logic                     grid_ready,
  output logic                     row_valid,
  output logic [COLS-1:0]          row_data,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     row_last,
  input  logic                     row_ready,
  output logic [GENW-1:0]          gen_count,
  output logic                     busy
);

  localparam int GW   = ROWS * COLS;
  localparam int IDXW = $clog2(ROWS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWS - 1);

  tx_state_t         state_q, state_d;
  logic [GW-1:0]     active_q, active_d;
  logic [IDXW-1:0]   row_idx_q, row_idx_d;
  logic [GENW-1:0]   gen_q, gen_d;

  logic              pend_load_s;
  logic              pend_clear_s;
  logic              pend_full_s;
  logic [GW-1:0]     pend_data_s;

  logic              accept_s;
  logic              send_s;
  logic              beat_hs_s;
  logic              at_last_s;

  // grid_ready depends only on the pending flag, never on row_ready.
  assign accept_s  = grid_valid & ~pend_full_s;
  assign send_s    = (state_q == SEND);
  assign beat_hs_s = send_s & row_ready;
  assign at_last_s = (row_idx_q == LAST_IDX);

  grid_hold_reg #(
    .W (GW)
  ) u_pending (
    .clk   (clk),
    .reset (reset),
    .load  (pend_load_s),
    .clear (pend_clear_s),
    .d     (grid),
    .q     (pend_data_s),
    .full  (pend_full_s)
  );

  // Next-state, frame hand-over and pending-slot control.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    row_idx_d    = row_idx_q;
    gen_d        = gen_q;
    pend_load_s  = 1'b0;
    pend_clear_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          active_d  = grid;
          row_idx_d = {IDXW{1'b0}};
          state_d   = SEND;
        end else begin
          state_d   = IDLE;
        end
      end
      SEND: begin
        if (beat_hs_s && at_last_s) begin
          gen_d     = gen_q + GENW'(1);
          row_idx_d = {IDXW{1'b0}};
          // The pending slot is served first; a direct accept is only
          // possible here when the slot is empty.
          if (pend_full_s) begin
            active_d     = pend_data_s;
            pend_clear_s = 1'b1;
          end else if (accept_s) begin
            active_d = grid;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beat_hs_s) begin
            row_idx_d = row_idx_q + IDXW'(1);
          end else begin
            row_idx_d = row_idx_q;
          end
          pend_load_s = accept_s;
        end
      end
      default: begin
        state_d   = IDLE;
        row_idx_d = {IDXW{1'b0}};
      end
    endcase
  end

  // Frame state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      active_q  <= {GW{1'b0}};
      row_idx_q <= {IDXW{1'b0}};
      gen_q     <= {GENW{1'b0}};
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      row_idx_q <= row_idx_d;
      gen_q     <= gen_d;
    end
  end

  assign grid_ready = ~pend_full_s;
  assign row_valid  = send_s;
  assign row_data   = send_s ? active_q[row_idx_q*COLS +: COLS] : {COLS{1'b0}};
  assign row_idx    = row_idx_q;
  assign row_last   = send_s & at_last_s;
  assign gen_count  = gen_q;
  assign busy       = send_s | pend_full_s;

endmodule : grid_row_tx

// File: doc/grid_row_tx.md
Name: grid_row_tx

Overview:
- Transmit side of the grid interface: the evolution datapath produces a full 64-bit generation word; this block serialises it into row-wide beats for a downstream consumer (LED matrix driver, UART framer).
- Accepts one grid snapshot per valid/ready handshake and emits ROWS beats with row index and last flag.
- Holds one further snapshot so the next generation can be captured while the current one streams.
- Counts completed frames.

Parameters:
- ROWS, 8, number of grid rows (beats per frame).
- COLS, 8, cells per row (beat width); grid width is ROWS*COLS.
- GENW, 16, width of the frame counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- grid_valid  in  1  upstream snapshot valid.
- grid  in  ROWS*COLS  snapshot; row r = grid[r*COLS +: COLS], bit c = column c.
- grid_ready  out  1  snapshot can be accepted this cycle.
- row_valid  out  1  beat valid.
- row_data  out  COLS  current row cells.
- row_idx  out  $clog2(ROWS)  index of current row, 0 first.
- row_last  out  1  high with row_idx == ROWS-1.
- row_ready  in  1  downstream accepts beat.
- gen_count  out  GENW  completed frames, wraps modulo 2^GENW.
- busy  out  1  frame streaming or snapshot pending.

Behaviour:
- Reset (reset low, asynchronous) forces the following immediately:
  - state IDLE; active and pending registers cleared; pending_full 0.
  - row_valid 0, row_data 0, row_idx 0, row_last 0, gen_count 0, busy 0.
  - grid_ready is 1 after reset release.
  - Reset mid-frame discards the frame and any pending snapshot without completing it; gen_count is not incremented.
- grid_ready = !pending_full (combinational, in both states).
- Accept = grid_valid & grid_ready, sampled at the rising edge.
- State IDLE:
  - On accept: load grid into active, row_idx <= 0, go SEND.
  - First beat (row_valid=1) appears the cycle after accept, so latency is 1 clock.
- State SEND:
  - row_valid = 1; row_data = active[row_idx*COLS +: COLS]; row_last = (row_idx == ROWS-1).
  - row_data, row_idx and row_last stay stable while row_valid & !row_ready; no beat is dropped or repeated.
  - On handshake with a non-last row: row_idx increments.
  - An accept during SEND writes into pending and sets pending_full.
- On the last-row handshake:
  - gen_count increments.
  - If pending_full: active <= pending, pending_full <= 0, row_idx <= 0, stay SEND. Row 0 of the new frame follows with no bubble.
  - Else if an accept occurs in the same cycle (possible because pending is empty, so grid_ready=1): active <= grid directly, row_idx <= 0, stay SEND.
  - Else: go IDLE, row_valid 0 the next cycle.
- An accept while pending_full is impossible, because grid_ready=0.
- An upstream that holds grid_valid high keeps its data stable until accepted.
- busy = (state == SEND) | pending_full.
- gen_count wraps from 2^GENW-1 to 0 with no flag.
- Arithmetic: row_idx is a plain binary counter compared against ROWS-1; ROWS need not be a power of two.
- No combinational path from row_ready to grid_ready.

Decomposition:
- Shared package gol_pkg:
  - ROWS/COLS defaults and GRID_W = ROWS*COLS.
  - Typedef grid_t (logic [GRID_W-1:0]) and row_t (logic [COLS-1:0]).
  - State enum tx_state_t {IDLE, SEND}.
- One sub-module grid_hold_reg: a single-entry snapshot register with load/clear and a full flag, used for the pending slot.
- Row selection and FSM stay in grid_row_tx.

Test Plan:
1. Reset release, then grid=64'h0000_0000_0000_0700, grid_valid 1 cycle, row_ready=1.
   - Expect 8 consecutive beats, idx 0..7, row_data 00,07,00,00,00,00,00,00.
   - row_last only on idx 7; gen_count 0->1; busy low one cycle later.
2. Backpressure: same frame, row_ready toggled 1,0,0,1,...
   - Every beat is held stable while stalled; exactly 8 beats delivered in order; gen_count=1.
3. Two snapshots back-to-back: A=64'h0102_0304_0506_0708, then B=64'hFFFF_FFFF_FFFF_FFFF presented during row 2 of A.
   - B is accepted and grid_ready drops.
   - Row 0 of B (FF) directly follows row 7 of A (01) with no idle cycle; gen_count=2 after B completes.
4. Third snapshot C presented while B is pending.
   - grid_ready stays 0 until A's last handshake; C is accepted only after B moves to active.
   - Order A, B, C preserved.
5. Simultaneous event: pending empty, new grid presented exactly on A's last-row handshake.
   - The grid is accepted that cycle and its row 0 appears next cycle; state stays SEND.
6. Reset asserted asynchronously mid-frame at row 4 with one snapshot pending.
   - row_valid drops without waiting for a clock; after release, idle with gen_count=0 and grid_ready=1.
   - Pending data is never emitted.
